io_input_port: RTL and testbench
================================

Name: io_input_port

Overview:
- Buffered input-device adapter that sits directly upstream of the processor's input port.
- External device side: pushes bytes into an internal FIFO.
- Processor side: presents one byte at a time on the processor data-input and data-ready lines, using a four-phase ready/ACK handshake.
- The data-ready output also drives the processor's input-ready interrupt source, so it must be glitch-free (registered).

Parameters:
- dataWidth, 8, width of each byte; matches the processor data-RAM width.
- depthLog2, 3, log2 of FIFO depth (default depth 8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- devData  input  dataWidth  byte from the external device.
- devWrEn  input  1  push devData this cycle.
- devFull  output  1  FIFO full; the device must not push.
- devOverflow  output  1  sticky flag: a push was dropped.
- clrOverflow  input  1  clears devOverflow.
- dataOut  output  dataWidth  byte to the processor input port.
- dataReady  output  1  to the processor input-ready line; dataOut is valid.
- ack  input  1  from the processor input-ACK line.
- count  output  depthLog2+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, highest priority, also mid-handshake):
  - At the edge: rdPtr=wrPtr=0, count=0, devFull=0, devOverflow=0, dataOut=0, dataReady=0, state=IDLE.
  - Buffered bytes are discarded.
- FIFO:
  - Circular buffer of 2**depthLog2 entries.
  - Pointers wrap modulo depth; count runs 0..depth.
  - devFull = (count==depth), combinational from count.
- Push: when devWrEn=1 and (not full, or a pop occurs the same edge), write at wrPtr, wrPtr++, count++.
- Push when full with no same-edge pop: byte dropped; devOverflow<=1, sticky.
- Simultaneous push and pop: both proceed, count unchanged. This holds at full (no overflow) and at count=1.
- clrOverflow=1: devOverflow<=0 unless a drop occurs the same edge; the drop wins.
- Handshake FSM, all outputs registered:
  - IDLE:
    - If count>0 and ack==0: dataOut<=mem[rdPtr], dataReady<=1, go to OFFER.
    - If ack==1 (stale ACK): stay in IDLE.
  - OFFER:
    - dataOut and dataReady held stable.
    - When ack==1 is sampled: pop (rdPtr++, count--), dataReady<=0, go to WAIT_LOW.
  - WAIT_LOW: when ack==0 is sampled, go to IDLE.
- Latency:
  - Byte pushed into an empty FIFO at edge E0 → dataReady=1 after edge E1.
  - ACK sampled at edge A → dataReady=0 after A.
  - Back-to-back bytes: the next dataReady rises at the earliest one edge after ack is seen low.
- dataOut is not cleared on pop; it holds the last value until the next offer.
- A byte pushed while in OFFER never changes the offered dataOut.
- A push in the same edge the FSM leaves IDLE is counted, but is not the offered byte unless the FIFO was empty; an empty FIFO means no offer that edge.
- ack is assumed synchronous to clk (the processor controller drives it).

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=2'b00, OFFER=2'b01, WAIT_LOW=2'b10.
  - Default data width constant (8), shared with the processor top.
- Sub-module io_fifo:
  - Parameterised synchronous FIFO: push/pop, count, full/empty, wr/rd pointers.
  - io_input_port contains the handshake FSM, overflow flag, and output registers.

Test Plan:
- Reset, then push 0x5A at edge 1 → dataReady=1 and dataOut=0x5A after edge 2; raise ack → dataReady=0 and count=0 the next edge; drop ack → IDLE.
- Push 0x01..0x03 back-to-back, processor ACKs each → dataOut sequence 0x01, 0x02, 0x03 in order; dataReady low for ≥1 cycle between bytes; count returns to 0.
- Push 9 bytes with ack held 0 → devFull=1 after the 8th; the 9th is dropped; devOverflow=1; drain yields exactly bytes 1..8.
- FIFO full, in OFFER: assert devWrEn and ack in the same cycle → pop and push both occur; count stays 8; devOverflow stays 0; the pushed byte is delivered last.
- Assert reset while in OFFER with 4 bytes buffered → next edge dataReady=0, count=0, dataOut=0; a subsequent push behaves as in scenario 1.
- Hold ack=1 from reset while pushing 0x77 → dataReady stays 0; release ack → dataReady=1, dataOut=0x77 one edge later.

Source files
------------

// File: rtl/io_input_port_pkg.sv
// Shared definitions for the buffered input-device adapter.
//   DATA_WIDTH : default byte width, shared with the processor top
//   DEPTH_LOG2 : default log2 FIFO depth
//   state_e    : handshake FSM encoding
package io_input_port_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DEPTH_LOG2 = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        OFFER    = 2'b01,
        WAIT_LOW = 2'b10
    } state_e;

endpackage

// File: rtl/io_input_port_fifo.sv
// io_fifo: parameterised synchronous circular-buffer FIFO.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, wr_data     : write request and data
//   pop               : read request (caller guarantees not empty)
//   rd_data           : entry at the read pointer (combinational)
//   count, full, empty: occupancy status
// A push while full is accepted only when a pop happens on the same edge.
module io_fifo
    import io_input_port_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_WIDTH,
    parameter int unsigned depthLog2 = DEPTH_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [dataWidth-1:0] wr_data,
    input  logic                 pop,
    output logic [dataWidth-1:0] rd_data,
    output logic [depthLog2:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned DEPTH = 1 << depthLog2;

    logic [dataWidth-1:0] mem_q [DEPTH];
    logic [depthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [depthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic [depthLog2:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == (depthLog2+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + depthLog2'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + depthLog2'(1);
        if (do_push && !do_pop)      count_d = count_q + (depthLog2+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (depthLog2+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/io_input_port.sv
// io_input_port: buffers bytes from an external device and presents them to
// the processor input port with a four-phase ready/ACK handshake.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   devData, devWrEn           : device byte and push strobe
//   devFull                    : FIFO full, device must not push
//   devOverflow, clrOverflow   : sticky dropped-push flag and its clear
//   dataOut, dataReady         : registered byte/valid to the processor
//   ack                        : processor input-ACK (synchronous to clk)
//   count                      : FIFO occupancy
//
// state    | meaning
// IDLE     | nothing offered; offer head byte when FIFO non-empty and ack low
// OFFER    | dataOut/dataReady held; pop on ack high
// WAIT_LOW | byte consumed; wait for ack to return low
module io_input_port
    import io_input_port_pkg::*;
#(
    parameter int unsigned dataWidth = DATA_WIDTH,
    parameter int unsigned depthLog2 = DEPTH_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [dataWidth-1:0] devData,
    input  logic                 devWrEn,
    output logic                 devFull,
    output logic                 devOverflow,
    input  logic                 clrOverflow,
    output logic [dataWidth-1:0] dataOut,
    output logic                 dataReady,
    input  logic                 ack,
    output logic [depthLog2:0]   count
);

    state_e               state_q, state_d;
    logic [dataWidth-1:0] data_out_q, data_out_d;
    logic                 ready_q, ready_d;
    logic                 ovf_q, ovf_d;
    logic                 pop;
    logic                 drop;
    logic [dataWidth-1:0] head;
    logic                 fifo_full, fifo_empty;

    io_fifo #(
        .dataWidth (dataWidth),
        .depthLog2 (depthLog2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (devWrEn),
        .wr_data (devData),
        .pop     (pop),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A push at full is only dropped when no pop frees a slot on that edge.
    assign drop = devWrEn && fifo_full && !pop;

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        ready_d    = ready_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ack && !fifo_empty) begin
                    data_out_d = head;
                    ready_d    = 1'b1;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (ack) begin
                    pop     = 1'b1;
                    ready_d = 1'b0;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!ack) state_d = IDLE;
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)             ovf_d = 1'b1;
        else if (clrOverflow) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
        end
    end

    assign devFull     = fifo_full;
    assign devOverflow = ovf_q;
    assign dataOut     = data_out_q;
    assign dataReady   = ready_q;

endmodule

// File: tb/tb_io_input_port.sv
module tb_io_input_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] devData;
    logic       devWrEn;
    logic       devFull;
    logic       devOverflow;
    logic       clrOverflow;
    logic [7:0] dataOut;
    logic       dataReady;
    logic       ack;
    logic [3:0] count;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_q[$];

    io_input_port #(.dataWidth(8), .depthLog2(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .devData     (devData),
        .devWrEn     (devWrEn),
        .devFull     (devFull),
        .devOverflow (devOverflow),
        .clrOverflow (clrOverflow),
        .dataOut     (dataOut),
        .dataReady   (dataReady),
        .ack         (ack),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: on each new offer, pop the scoreboard and compare the byte;
    // while the offer is held, dataOut must not move.
    logic       rdy_prev = 1'b0;
    logic [7:0] held;
    always @(negedge clk) begin
        if (!reset) begin
            if (dataReady && !rdy_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_offer", 1, 0);
                end else begin
                    chk("offer_data", dataOut, exp_q.pop_front());
                end
                held = dataOut;
            end else if (dataReady && rdy_prev) begin
                if (dataOut !== held) chk("offer_stable", dataOut, held);
            end
        end
        rdy_prev = reset ? 1'b0 : dataReady;
    end

    task automatic push(input logic [7:0] b, input bit accepted);
        devData = b;
        devWrEn = 1'b1;
        if (accepted) exp_q.push_back(b);
        tick();
        devWrEn = 1'b0;
    endtask

    task automatic ack_byte();
        for (int i = 0; i < 20 && !dataReady; i++) tick();
        chk("offer_wait", dataReady, 1);
        ack = 1'b1;
        tick();
        chk("ready_drop_on_ack", dataReady, 0);
        ack = 1'b0;
        tick();
        chk("ready_low_gap", dataReady, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic single_byte(input logic [7:0] b);
        push(b, 1'b1);
        chk("s_count_after_push", count, 1);
        chk("s_ready_e1", dataReady, 0);
        tick();
        chk("s_ready_e2", dataReady, 1);
        chk("s_dataout_e2", dataOut, b);
        ack = 1'b1;
        tick();
        chk("s_ready_after_ack", dataReady, 0);
        chk("s_count_after_ack", count, 0);
        chk("s_dataout_held", dataOut, b);
        ack = 1'b0;
        tick();
        tick();
        chk("s_idle_no_offer", dataReady, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; devData = '0; devWrEn = 1'b0; clrOverflow = 1'b0; ack = 1'b0;
        do_reset();
        chk("rst_ready", dataReady, 0);
        chk("rst_count", count, 0);
        chk("rst_full", devFull, 0);
        chk("rst_ovf", devOverflow, 0);
        chk("rst_dataout", dataOut, 0);

        // Scenario 1: single byte
        single_byte(8'h5A);

        // Scenario 2: three back-to-back bytes
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        for (int k = 0; k < 3; k++) ack_byte();
        chk("b2b_count_zero", count, 0);

        // Scenario 3: overfill with ack held low
        for (int k = 1; k <= 8; k++) push(8'hA0 + 8'(k), 1'b1);
        chk("fill_count8", count, 8);
        chk("fill_full", devFull, 1);
        chk("fill_no_ovf_yet", devOverflow, 0);
        push(8'hA9, 1'b0);
        chk("drop_count8", count, 8);
        chk("drop_ovf", devOverflow, 1);
        clrOverflow = 1'b1;
        push(8'hAA, 1'b0);
        chk("drop_beats_clear", devOverflow, 1);
        tick();
        clrOverflow = 1'b0;
        chk("clear_ovf", devOverflow, 0);

        // Scenario 4: full, offering; push and ack on the same edge
        chk("full_offering", dataReady, 1);
        ack = 1'b1;
        push(8'hB0, 1'b1);
        chk("simul_count8", count, 8);
        chk("simul_no_ovf", devOverflow, 0);
        chk("simul_ready_low", dataReady, 0);
        ack = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) ack_byte();
        chk("drain_count0", count, 0);
        for (int k = 0; k < 4; k++) tick();
        chk("drain_no_extra", dataReady, 0);
        chk("drain_queue_empty", exp_q.size(), 0);

        // Scenario 5: reset mid-offer with 4 buffered
        for (int k = 0; k < 4; k++) push(8'hC0 + 8'(k), 1'b1);
        chk("pre_rst_offer", dataReady, 1);
        chk("pre_rst_count4", count, 4);
        reset = 1'b1;
        tick();
        chk("mid_rst_ready", dataReady, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_dataout", dataOut, 0);
        reset = 1'b0;
        exp_q.delete();
        tick();
        single_byte(8'h3C);

        // Scenario 6: stale ack from reset
        ack = 1'b1;
        do_reset();
        push(8'h77, 1'b1);
        tick();
        tick();
        chk("stale_ack_no_offer", dataReady, 0);
        chk("stale_ack_count", count, 1);
        ack = 1'b0;
        tick();
        chk("release_ready", dataReady, 1);
        chk("release_dataout", dataOut, 8'h77);
        ack_byte();
        chk("final_count0", count, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
